// File: rtl/aq_jpeg_header_gen.sv
// rtl/aq_jpeg_header_gen.sv - baseline JPEG marker stream generator (SOI..SOS)
//
// Purpose: on Start, emits SOI, DQT, SOF0, DHT (one segment per table), an
// optional DRI and SOS as a byte stream that goes ahead of the scan data.
// Quantisation and Huffman bytes are read from external synchronous memories.
//
// Ports:
//   rst, clk                 asynchronous active-low reset, clock
//   Start                    one-cycle request, ignored while Busy
//   InWidth, InHeight        image geometry (captured at Start)
//   InComp                   1 = grayscale, anything else = YCbCr
//   InSubSamplingW/H         component-1 sampling factors
//   InRestart                restart interval, 0 = no DRI
//   QtAddr / QtData          quant memory {table, zigzag index}, 1-cycle latency
//   HtAddr / HtData          Huffman memory (counts / symbols), 1-cycle latency
//   OutData/OutValid/OutLast/OutReady   header byte stream
//   Busy, Done               status; Done pulses after the last byte is taken
module aq_jpeg_header_gen (
   input  logic        rst,
   input  logic        clk,
   input  logic        Start,
   input  logic [15:0] InWidth,
   input  logic [15:0] InHeight,
   input  logic [2:0]  InComp,
   input  logic [1:0]  InSubSamplingW,
   input  logic [1:0]  InSubSamplingH,
   input  logic [15:0] InRestart,
   output logic [6:0]  QtAddr,
   input  logic [7:0]  QtData,
   output logic [9:0]  HtAddr,
   input  logic [7:0]  HtData,
   output logic [7:0]  OutData,
   output logic        OutValid,
   output logic        OutLast,
   input  logic        OutReady,
   output logic        Busy,
   output logic        Done
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_SOI      = 4'd1;
   localparam logic [3:0] S_DQT_HDR  = 4'd2;
   localparam logic [3:0] S_DQT_TBL  = 4'd3;
   localparam logic [3:0] S_SOF      = 4'd4;
   localparam logic [3:0] S_DHT_SCAN = 4'd5;
   localparam logic [3:0] S_DHT_HDR  = 4'd6;
   localparam logic [3:0] S_DHT_CNT  = 4'd7;
   localparam logic [3:0] S_DHT_SYM  = 4'd8;
   localparam logic [3:0] S_DRI      = 4'd9;
   localparam logic [3:0] S_SOS      = 4'd10;
   localparam logic [3:0] S_DONE     = 4'd11;

   logic [3:0]  st;
   logic [7:0]  cnt;
   logic [1:0]  tbl;
   logic [7:0]  sum;
   logic [1:0]  ph;
   logic [15:0] cap_w;
   logic [15:0] cap_h;
   logic [15:0] cap_rs;
   logic [1:0]  cap_sw;
   logic [1:0]  cap_sh;
   logic        cap_gray;

   logic [7:0]  cbyte;
   logic        clast;
   logic        fetch_qt;
   logic        fetch_ht;
   logic [6:0]  qt_addr_n;
   logic [9:0]  ht_addr_n;
   logic [7:0]  sos_k;
   logic [5:0]  qidx;
   logic [15:0] dht_len;
   logic [7:0]  nf;
   logic [3:0]  adv_st;
   logic [1:0]  adv_tbl;
   logic [3:0]  tend_st;
   logic [1:0]  tend_tbl;
   logic        out_free;
   logic        emit_state;
   logic        byte_load;

   assign out_free   = !OutValid || OutReady;
   assign emit_state = (st != S_IDLE) && (st != S_DHT_SCAN) && (st != S_DONE);
   // A memory byte is issued in phase 0, in flight in phase 1 and lands in
   // phase 2; the output register is always empty by phase 2.
   assign byte_load  = emit_state &&
                       ((ph == 2'd2) || ((ph == 2'd0) && out_free && !fetch_qt && !fetch_ht));

   always_comb begin
      cbyte     = 8'h00;
      clast     = 1'b0;
      fetch_qt  = 1'b0;
      fetch_ht  = 1'b0;
      qt_addr_n = 7'd0;
      ht_addr_n = 10'd0;
      qidx      = cnt[5:0] - 6'd1;
      dht_len   = 16'd19 + {8'd0, sum};
      nf        = cap_gray ? 8'd1 : 8'd3;
      // Gray SOS has only one component pair: skip the two unused pairs so
      // the trailing 00 3F 00 shares the same index positions.
      sos_k     = (cap_gray && cnt >= 8'd7) ? cnt + 8'd4 : cnt;
      case (st)
         S_SOI: begin
            cbyte = (cnt == 8'd0) ? 8'hFF : 8'hD8;
            clast = (cnt == 8'd1);
         end
         S_DQT_HDR: begin
            case (cnt)
               8'd0:    cbyte = 8'hFF;
               8'd1:    cbyte = 8'hDB;
               8'd2:    cbyte = 8'h00;
               default: cbyte = cap_gray ? 8'h43 : 8'h84;
            endcase
            clast = (cnt == 8'd3);
         end
         S_DQT_TBL: begin
            cbyte     = {7'd0, tbl[0]};
            fetch_qt  = (cnt != 8'd0);
            qt_addr_n = {tbl[0], qidx};
            clast     = (cnt == 8'd64);
         end
         S_SOF: begin
            case (cnt)
               8'd0:    cbyte = 8'hFF;
               8'd1:    cbyte = 8'hC0;
               8'd2:    cbyte = 8'h00;
               8'd3:    cbyte = cap_gray ? 8'h0B : 8'h11;
               8'd4:    cbyte = 8'h08;
               8'd5:    cbyte = cap_h[15:8];
               8'd6:    cbyte = cap_h[7:0];
               8'd7:    cbyte = cap_w[15:8];
               8'd8:    cbyte = cap_w[7:0];
               8'd9:    cbyte = nf;
               8'd10:   cbyte = 8'h01;
               8'd11:   cbyte = {2'b00, cap_sw, 2'b00, cap_sh};
               8'd12:   cbyte = 8'h00;
               8'd13:   cbyte = 8'h02;
               8'd14:   cbyte = 8'h11;
               8'd15:   cbyte = 8'h01;
               8'd16:   cbyte = 8'h03;
               8'd17:   cbyte = 8'h11;
               8'd18:   cbyte = 8'h01;
               default: cbyte = 8'h00;
            endcase
            clast = cap_gray ? (cnt == 8'd12) : (cnt == 8'd18);
         end
         S_DHT_HDR: begin
            case (cnt)
               8'd0:    cbyte = 8'hFF;
               8'd1:    cbyte = 8'hC4;
               8'd2:    cbyte = dht_len[15:8];
               8'd3:    cbyte = dht_len[7:0];
               default: cbyte = {3'b000, tbl[0], 3'b000, tbl[1]};
            endcase
            clast = (cnt == 8'd4);
         end
         S_DHT_CNT: begin
            fetch_ht  = 1'b1;
            ht_addr_n = {tbl, 1'b0, 3'b000, cnt[3:0]};
            clast     = (cnt == 8'd15);
         end
         S_DHT_SYM: begin
            fetch_ht  = 1'b1;
            ht_addr_n = {tbl, 1'b1, cnt[6:0]};
            clast     = (cnt == sum - 8'd1);
         end
         S_DRI: begin
            case (cnt)
               8'd0:    cbyte = 8'hFF;
               8'd1:    cbyte = 8'hDD;
               8'd2:    cbyte = 8'h00;
               8'd3:    cbyte = 8'h04;
               8'd4:    cbyte = cap_rs[15:8];
               default: cbyte = cap_rs[7:0];
            endcase
            clast = (cnt == 8'd5);
         end
         S_SOS: begin
            case (sos_k)
               8'd0:    cbyte = 8'hFF;
               8'd1:    cbyte = 8'hDA;
               8'd2:    cbyte = 8'h00;
               8'd3:    cbyte = cap_gray ? 8'h08 : 8'h0C;
               8'd4:    cbyte = nf;
               8'd5:    cbyte = 8'h01;
               8'd6:    cbyte = 8'h00;
               8'd7:    cbyte = 8'h02;
               8'd8:    cbyte = 8'h11;
               8'd9:    cbyte = 8'h03;
               8'd10:   cbyte = 8'h11;
               8'd12:   cbyte = 8'h3F;
               default: cbyte = 8'h00;
            endcase
            clast = (sos_k == 8'd13);
         end
         default: ;
      endcase
   end

   // Where to go after the last byte of the current segment piece.
   always_comb begin
      if (tbl == (cap_gray ? 2'd1 : 2'd3)) begin
         tend_st  = (cap_rs != 16'd0) ? S_DRI : S_SOS;
         tend_tbl = tbl;
      end else begin
         tend_st  = S_DHT_SCAN;
         tend_tbl = tbl + 2'd1;
      end
      adv_st  = st;
      adv_tbl = tbl;
      case (st)
         S_SOI:     adv_st = S_DQT_HDR;
         S_DQT_HDR: begin adv_st = S_DQT_TBL; adv_tbl = 2'd0; end
         S_DQT_TBL: begin
            if (tbl[0] == !cap_gray) begin
               adv_st  = S_SOF;
               adv_tbl = 2'd0;
            end else begin
               adv_tbl = tbl + 2'd1;
            end
         end
         S_SOF:     begin adv_st = S_DHT_SCAN; adv_tbl = 2'd0; end
         S_DHT_HDR: adv_st = S_DHT_CNT;
         S_DHT_CNT: begin
            if (sum == 8'd0) begin
               adv_st  = tend_st;
               adv_tbl = tend_tbl;
            end else begin
               adv_st = S_DHT_SYM;
            end
         end
         S_DHT_SYM: begin adv_st = tend_st; adv_tbl = tend_tbl; end
         S_DRI:     adv_st = S_SOS;
         S_SOS:     adv_st = S_DONE;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= S_IDLE;
         cnt      <= 8'd0;
         tbl      <= 2'd0;
         sum      <= 8'd0;
         ph       <= 2'd0;
         cap_w    <= 16'd0;
         cap_h    <= 16'd0;
         cap_rs   <= 16'd0;
         cap_sw   <= 2'd0;
         cap_sh   <= 2'd0;
         cap_gray <= 1'b0;
         OutData  <= 8'd0;
         OutValid <= 1'b0;
         OutLast  <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         QtAddr   <= 7'd0;
         HtAddr   <= 10'd0;
      end else begin
         Done <= 1'b0;
         if (OutValid && OutReady) begin
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
         end
         case (st)
            S_IDLE: begin
               if (Start) begin
                  cap_w    <= InWidth;
                  cap_h    <= InHeight;
                  cap_rs   <= InRestart;
                  cap_sw   <= InSubSamplingW;
                  cap_sh   <= InSubSamplingH;
                  cap_gray <= (InComp == 3'd1);
                  Busy     <= 1'b1;
                  st       <= S_SOI;
                  cnt      <= 8'd0;
                  tbl      <= 2'd0;
                  ph       <= 2'd0;
               end
            end
            S_DHT_SCAN: begin
               // Pipelined count read: address k goes out at cnt=k, its data
               // is summed at cnt=k+2. The output byte still pending drains
               // independently meanwhile.
               if (cnt < 8'd16) HtAddr <= {tbl, 1'b0, 3'b000, cnt[3:0]};
               if (cnt >= 8'd2) sum <= sum + HtData;
               if (cnt == 8'd17) begin
                  st  <= S_DHT_HDR;
                  cnt <= 8'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE: begin
               if (OutValid && OutReady) begin
                  Done <= 1'b1;
                  Busy <= 1'b0;
                  st   <= S_IDLE;
               end
            end
            default: begin
               if (ph == 2'd1) begin
                  ph <= 2'd2;
               end else if (ph == 2'd2) begin
                  OutData  <= fetch_qt ? QtData : HtData;
                  OutValid <= 1'b1;
                  ph       <= 2'd0;
               end else if (out_free) begin
                  if (fetch_qt) begin
                     QtAddr <= qt_addr_n;
                     ph     <= 2'd1;
                  end else if (fetch_ht) begin
                     HtAddr <= ht_addr_n;
                     ph     <= 2'd1;
                  end else begin
                     OutData  <= cbyte;
                     OutValid <= 1'b1;
                     OutLast  <= (st == S_SOS) && clast;
                  end
               end
               if (byte_load) begin
                  if (clast) begin
                     st  <= adv_st;
                     tbl <= adv_tbl;
                     cnt <= 8'd0;
                     if (adv_st == S_DHT_SCAN) sum <= 8'd0;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aq_jpeg_header_gen.sv
// tb/tb_aq_jpeg_header_gen.sv - directed self-checking bench for aq_jpeg_header_gen
module tb_aq_jpeg_header_gen;

   logic        rst;
   logic        clk;
   logic        Start;
   logic [15:0] InWidth;
   logic [15:0] InHeight;
   logic [2:0]  InComp;
   logic [1:0]  InSubSamplingW;
   logic [1:0]  InSubSamplingH;
   logic [15:0] InRestart;
   logic [6:0]  QtAddr;
   logic [7:0]  QtData;
   logic [9:0]  HtAddr;
   logic [7:0]  HtData;
   logic [7:0]  OutData;
   logic        OutValid;
   logic        OutLast;
   logic        OutReady;
   logic        Busy;
   logic        Done;

   aq_jpeg_header_gen dut (
      .rst(rst), .clk(clk), .Start(Start),
      .InWidth(InWidth), .InHeight(InHeight), .InComp(InComp),
      .InSubSamplingW(InSubSamplingW), .InSubSamplingH(InSubSamplingH),
      .InRestart(InRestart),
      .QtAddr(QtAddr), .QtData(QtData), .HtAddr(HtAddr), .HtData(HtData),
      .OutData(OutData), .OutValid(OutValid), .OutLast(OutLast),
      .OutReady(OutReady), .Busy(Busy), .Done(Done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] qt_mem [128];
   logic [7:0] ht_mem [1024];

   always @(posedge clk) begin
      QtData <= qt_mem[QtAddr];
      HtData <= ht_mem[HtAddr];
   end

   int errs;
   int checks;
   int stall_err;
   int nst;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic       lst_q[$];
   logic [7:0] ref_q[$];

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int gb(input int i);
      if (i < got_q.size()) return int'(got_q[i]);
      return -1;
   endfunction

   task automatic sp(input string tag, input int idx, input int val);
      check(tag, gb(idx), val);
   endtask

   task automatic set_cfg(input logic [2:0] comp, input logic [15:0] w, input logic [15:0] h,
                          input logic [1:0] sw, input logic [1:0] sh, input logic [15:0] rs);
      InComp = comp; InWidth = w; InHeight = h;
      InSubSamplingW = sw; InSubSamplingH = sh; InRestart = rs;
   endtask

   task automatic push16(input int v);
      exp_q.push_back(8'((v >> 8) & 255));
      exp_q.push_back(8'(v & 255));
   endtask

   // Reference stream built straight from the marker layout.
   task automatic build_exp(input bit gray, input int w, input int h,
                            input int sw, input int sh, input int rs);
      int nt;
      int nf;
      int s;
      nt = gray ? 1 : 2;
      nf = gray ? 1 : 3;
      exp_q.delete();
      exp_q.push_back(8'hFF); exp_q.push_back(8'hD8);
      exp_q.push_back(8'hFF); exp_q.push_back(8'hDB);
      push16(2 + 65 * nt);
      for (int t = 0; t < nt; t++) begin
         exp_q.push_back(8'(t));
         for (int i = 0; i < 64; i++) exp_q.push_back(qt_mem[t * 64 + i]);
      end
      exp_q.push_back(8'hFF); exp_q.push_back(8'hC0);
      push16(8 + 3 * nf);
      exp_q.push_back(8'h08);
      push16(h);
      push16(w);
      exp_q.push_back(8'(nf));
      for (int c = 1; c <= nf; c++) begin
         exp_q.push_back(8'(c));
         exp_q.push_back((c == 1) ? 8'((sw << 4) | sh) : 8'h11);
         exp_q.push_back((c == 1) ? 8'h00 : 8'h01);
      end
      for (int t = 0; t < 2 * nt; t++) begin
         s = 0;
         for (int i = 0; i < 16; i++) s += int'(ht_mem[t * 256 + i]);
         s = s % 256;
         exp_q.push_back(8'hFF); exp_q.push_back(8'hC4);
         push16(19 + s);
         exp_q.push_back(8'(((t & 1) << 4) | (t >> 1)));
         for (int i = 0; i < 16; i++) exp_q.push_back(ht_mem[t * 256 + i]);
         for (int i = 0; i < s; i++) exp_q.push_back(ht_mem[t * 256 + 128 + (i % 128)]);
      end
      if (rs != 0) begin
         exp_q.push_back(8'hFF); exp_q.push_back(8'hDD);
         push16(4);
         push16(rs);
      end
      exp_q.push_back(8'hFF); exp_q.push_back(8'hDA);
      push16(6 + 2 * nf);
      exp_q.push_back(8'(nf));
      for (int c = 1; c <= nf; c++) begin
         exp_q.push_back(8'(c));
         exp_q.push_back((c == 1) ? 8'h00 : 8'h11);
      end
      exp_q.push_back(8'h00); exp_q.push_back(8'h3F); exp_q.push_back(8'h00);
   endtask

   task automatic run_stream(input bit rnd, input int glitch_at, output int ndone);
      int cyc;
      bit hold_v;
      bit rdy;
      logic [7:0] hold_d;
      got_q.delete();
      lst_q.delete();
      ndone  = 0;
      hold_v = 1'b0;
      hold_d = 8'h00;
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      check("busy_after_start", int'(Busy), 1);
      cyc = 0;
      while (ndone == 0 && cyc < 20000) begin
         if (hold_v && (OutValid !== 1'b1 || OutData !== hold_d)) stall_err++;
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         OutReady = rdy;
         hold_v = OutValid && !rdy;
         if (hold_v) nst++;
         hold_d = OutData;
         if (OutValid && rdy) begin
            got_q.push_back(OutData);
            lst_q.push_back(OutLast);
         end
         if (cyc == glitch_at) begin
            Start = 1'b1;
            InWidth = 16'h1234;
            InComp = 3'd3;
            InRestart = 16'd9;
         end else begin
            Start = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (Done) begin
            ndone = 1;
            check("busy_at_done", int'(Busy), 0);
         end
      end
      if (ndone == 0) check("timeout", 0, 1);
      OutReady = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (Done) ndone++;
      end
   endtask

   task automatic cmp_stream(input string tag);
      int mis;
      int badl;
      int n;
      mis  = 0;
      badl = 0;
      n    = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      check({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < n; i++) begin
         if (got_q[i] !== exp_q[i]) mis++;
         if (lst_q[i] !== (i == exp_q.size() - 1)) badl++;
      end
      check({tag, "_bytes"}, mis, 0);
      check({tag, "_last"}, badl, 0);
   endtask

   int dc_cnt [16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
   int ac_cnt [16] = '{0, 2, 1, 3, 3, 2, 4, 3, 5, 5, 4, 4, 0, 0, 1, 125};

   task automatic load_counts();
      for (int t = 0; t < 4; t++)
         for (int i = 0; i < 16; i++)
            ht_mem[t * 256 + i] = 8'((t & 1) ? ac_cnt[i] : dc_cnt[i]);
   endtask

   initial begin
      int nd;
      int mis;
      errs = 0; checks = 0; stall_err = 0; nst = 0;
      for (int i = 0; i < 128; i++) qt_mem[i] = 8'(i * 7 + 3);
      for (int i = 0; i < 1024; i++) ht_mem[i] = 8'(i * 13 + 1);
      load_counts();
      rst = 1'b0; Start = 1'b0; OutReady = 1'b0;
      set_cfg(3'd1, 16'd16, 16'd8, 2'd1, 2'd1, 16'd0);
      repeat (3) @(negedge clk);
      check("rst_valid", int'(OutValid), 0);
      check("rst_last", int'(OutLast), 0);
      check("rst_data", int'(OutData), 0);
      check("rst_busy", int'(Busy), 0);
      check("rst_done", int'(Done), 0);
      check("rst_qtaddr", int'(QtAddr), 0);
      check("rst_htaddr", int'(HtAddr), 0);
      rst = 1'b1;
      @(negedge clk);

      // Gray 16x8, full-rate sink
      build_exp(1'b1, 16, 8, 1, 1, 0);
      run_stream(1'b0, -1, nd);
      cmp_stream("gray");
      check("gray_done_once", nd, 1);
      check("gray_total", got_q.size(), 310);
      sp("gray_soi0", 0, 'hFF); sp("gray_soi1", 1, 'hD8);
      sp("gray_dqt_m", 3, 'hDB); sp("gray_dqt_len", 5, 'h43); sp("gray_dqt_id", 6, 'h00);
      sp("gray_sof_len", 74, 'h0B); sp("gray_sof_h", 77, 'h08); sp("gray_sof_w", 79, 'h10);
      sp("gray_dht_len", 87, 'h1F); sp("gray_sos_m", 301, 'hDA); sp("gray_sos_len", 303, 'h08);
      ref_q = got_q;

      // Color 4:2:0 640x480
      set_cfg(3'd3, 16'd640, 16'd480, 2'd2, 2'd2, 16'd0);
      build_exp(1'b0, 640, 480, 2, 2, 0);
      run_stream(1'b0, -1, nd);
      cmp_stream("color");
      check("color_done_once", nd, 1);
      check("color_total", got_q.size(), 601);
      sp("color_dqt_len", 5, 'h84);
      sp("color_sof_len", 139, 'h11); sp("color_sof_hlo", 142, 'hE0); sp("color_sof_whi", 143, 'h02);
      sp("color_c1_samp", 147, 'h22); sp("color_c2_samp", 150, 'h11); sp("color_c3_tq", 154, 'h01);
      sp("color_dht_id0", 159, 'h00); sp("color_dht_id1", 192, 'h10);
      sp("color_dht_len1", 191, 'hB5);
      sp("color_dht_id2", 375, 'h01); sp("color_dht_id3", 408, 'h11);
      sp("color_sos_len", 590, 'h0C);

      // Color with restart interval 4
      set_cfg(3'd3, 16'd640, 16'd480, 2'd2, 2'd2, 16'd4);
      build_exp(1'b0, 640, 480, 2, 2, 4);
      run_stream(1'b0, -1, nd);
      cmp_stream("dri");
      check("dri_total", got_q.size(), 607);
      sp("dri_m", 588, 'hDD); sp("dri_l", 590, 'h04); sp("dri_rs", 592, 'h04);
      sp("dri_sos0", 593, 'hFF); sp("dri_sos1", 594, 'hDA);

      // Gray with random backpressure and an ignored mid-run Start
      set_cfg(3'd1, 16'd16, 16'd8, 2'd1, 2'd1, 16'd0);
      build_exp(1'b1, 16, 8, 1, 1, 0);
      run_stream(1'b1, 150, nd);
      cmp_stream("rnd");
      check("rnd_done_once", nd, 1);
      mis = 0;
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
         if (got_q[i] !== ref_q[i]) mis++;
      check("rnd_vs_ref_len", got_q.size(), ref_q.size());
      check("rnd_vs_ref", mis, 0);
      check("stall_hold", stall_err, 0);
      check("stalls_seen", int'(nst > 0), 1);

      // Reset in the middle of DQT
      set_cfg(3'd1, 16'd16, 16'd8, 2'd1, 2'd1, 16'd0);
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      OutReady = 1'b1;
      repeat (30) @(negedge clk);
      check("mid_busy", int'(Busy), 1);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", int'(OutValid), 0);
      check("mid_rst_busy", int'(Busy), 0);
      check("mid_rst_qtaddr", int'(QtAddr), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      build_exp(1'b1, 16, 8, 1, 1, 0);
      run_stream(1'b0, -1, nd);
      cmp_stream("after_rst");

      // DC0 table with all counts zero
      for (int i = 0; i < 16; i++) ht_mem[i] = 8'h00;
      build_exp(1'b1, 16, 8, 1, 1, 0);
      run_stream(1'b0, -1, nd);
      cmp_stream("zero");
      check("zero_total", got_q.size(), 298);
      sp("zero_len_hi", 86, 'h00); sp("zero_len_lo", 87, 'h13);
      sp("zero_next_ff", 105, 'hFF); sp("zero_next_c4", 106, 'hC4);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
